multi_down_timer: RTL and testbench
===================================

Name: multi_down_timer

Overview:
Parametrised multi-channel down-counting timer; successor of the single 16-bit down counter. NUM_CH independent channels, each with its own reload value, mode (free-running, cyclic, single-shot), and start/stop control. Sticky per-channel interrupt pending bits are combined into one irq line. Sits on the peripheral side, configured by a simple write strobe from the register block.

Parameters:
WIDTH, 16, counter and reload width per channel (2..32)
NUM_CH, 4, number of channels (1..16)
CH_IDX_W, $clog2(NUM_CH) (min 1), channel index width (derived, do not override)
PRESC_W, 8, prescaler divider width (used only with prescaler feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
cfg_we  in  1  configuration write strobe, one cycle
cfg_ch  in  CH_IDX_W  channel addressed by cfg_we
cfg_mode  in  2  00 free-running, 01 cyclic, 10 single, 11 reserved (behaves as 00)
cfg_load  in  WIDTH  reload value for addressed channel
start  in  NUM_CH  per-channel start pulse
stop  in  NUM_CH  per-channel stop pulse
irq_clr  in  NUM_CH  write-1-to-clear of pending bits
presc_div  in  PRESC_W  tick every presc_div+1 cycles (ignored without feature)
count  out  NUM_CH*WIDTH  flattened counts, channel i at [i*WIDTH +: WIDTH]
irq_pend  out  NUM_CH  sticky pending bits
irq  out  1  registered OR of irq_pend

Behaviour:
- Reset (async, high): every count = all-ones; reload = all-ones; mode = 00; state = IDLE; irq_pend = 0; irq = 0; prescaler counter = 0.
- Per-channel FSM states: IDLE, RUN, DONE.
- cfg_we to channel c: reload[c] <= cfg_load; count[c] <= cfg_load; mode[c] <= cfg_mode; state <= IDLE. This applies in any state. Same-cycle start/stop on c is ignored.
- Transitions:
  - start in IDLE: go to RUN; count is unchanged.
  - start in DONE: count <= reload, go to RUN.
  - start in RUN: no effect.
  - stop in RUN: go to IDLE, count held.
  - start and stop in the same cycle: stop wins.
- tick: a single-cycle enable shared by all channels. It is 1 every cycle without the feature.
- On a clock edge with tick=1 and state RUN:
  - count != 0: count <= count-1 (all modes).
  - count == 0, free-running: count <= all-ones (wrap), pend set.
  - count == 0, cyclic: count <= reload, pend set.
  - count == 0, single: count stays 0, state <= DONE, pend set.
- Period is reload+1 ticks. reload = 0 in cyclic gives a pend event every tick.
- irq_pend[c] is sticky and cleared by irq_clr[c]=1. A set event in the same cycle as clear wins (bit stays 1).
- irq is registered, so it lags irq_pend by 1 cycle.
- count and irq_pend are registered outputs, updated on the edge of the event.
- Arithmetic is modulo 2^WIDTH. There is no carry-out.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- Reset asserted mid-count returns everything to reset values immediately, regardless of clk.

Optional Feature:
Macro MULTI_DOWN_TIMER_PRESCALER_EN.
- Defined: a shared PRESC_W-bit prescaler counts 0..presc_div, then wraps to 0. tick=1 on the cycle the counter equals presc_div, so presc_div=0 gives a tick every cycle. The prescaler free-runs from reset, independent of channel state. A presc_div change takes effect at the next compare; if the counter is already above the new value, it wraps naturally via modulo.
- Not defined: tick tied to 1, presc_div unused, no prescaler flops.

Decomposition:
- Package timer_pkg: mode constants (MODE_FREE=2'b00, MODE_CYCLIC=2'b01, MODE_SINGLE=2'b10); FSM state encodings (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module timer_channel: one channel with its FSM, count, reload, mode and pend. It takes tick, a decoded cfg write, start, stop and irq_clr.
- The top level holds cfg_ch decode, the prescaler, the generate loop over NUM_CH, and the irq OR register.

Test Plan:
- Reset, then cfg ch0: load=3, mode=01, start[0] pulse, no prescaler. Count goes 3,2,1,0,3,2… with irq_pend[0] rising on the 0→3 edge and irq 1 cycle later.
- Ch1: load=2, mode=10, start. Count 2,1,0 holds. State DONE, pend set once. A second start reloads 2 and reruns.
- Ch2: load=1, mode=00. Count 1,0,FFFF,FFFE, pend set on wrap. irq_clr[2] in the same cycle as the next wrap event leaves pend=1.
- Stop on a running ch0 at count=5 holds 5. Start+stop in the same cycle keeps IDLE. cfg_we with start in the same cycle leaves the channel IDLE with count=cfg_load.
- Prescaler enabled, presc_div=3, ch3 cyclic load=1: count decrements once every 4 clk. Reset asserted asynchronously mid-run forces all counts to FFFF and irq=0 before the next edge.
- All 4 channels cyclic with load=0, started together: all pend bits set on the same edge. Clear one and check the others remain set.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared mode constants and per-channel FSM encoding for multi_down_timer.
package timer_pkg;

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_CYCLIC = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: reload/mode registers, IDLE/RUN/DONE FSM,
// sticky pending bit. State is exported on state_dbg for checkers.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             pend,
  output logic [1:0]       state_dbg
);

  // Control strobes are single-cycle and act on the edge they are sampled:
  // cfg_we overrides start/stop, stop overrides start, a pend set overrides irq_clr.
  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [1:0]       mode_q, mode_d;
  logic             pend_q, pend_d;
  logic             pend_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '1;
      reload_q <= '1;
      mode_q   <= MODE_FREE;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    pend_set = 1'b0;

    if (cfg_we) begin
      reload_d = cfg_load;
      count_d  = cfg_load;
      mode_d   = cfg_mode;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              pend_set = 1'b1;
              case (mode_q)
                MODE_CYCLIC: count_d = reload_q;
                MODE_SINGLE: state_d = ST_DONE;
                MODE_FREE:   count_d = '1;
                default:     count_d = '1;  // reserved mode behaves as free-running
              endcase
            end
          end
        end
        ST_DONE: begin
          if (start && !stop) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pend_d    = pend_set | (pend_q & ~irq_clr);
  assign count     = count_q;
  assign pend      = pend_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/multi_down_timer.sv
// Multi-channel down timer: cfg decode, shared tick, channel array, irq register.
// Optional shared prescaler enabled by MULTI_DOWN_TIMER_PRESCALER_EN.
module multi_down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PRESC_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [CH_IDX_W-1:0]     cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [WIDTH-1:0]        cfg_load,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       irq_clr,
  input  logic [PRESC_W-1:0]      presc_div,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       irq_pend,
  output logic                    irq,
  output logic [NUM_CH*2-1:0]     state_dbg
);

  logic tick;

`ifdef MULTI_DOWN_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_cnt;

  // Equality compare means a shrinking presc_div lets the counter run up and wrap.
  assign tick = (presc_cnt == presc_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + PRESC_W'(1);
  end
`else
  logic unused_presc;
  assign unused_presc = ^presc_div;
  assign tick         = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_hit;
    assign cfg_hit = cfg_we && (cfg_ch == CH_IDX_W'(i));

    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .cfg_we   (cfg_hit),
      .cfg_mode (cfg_mode),
      .cfg_load (cfg_load),
      .start    (start[i]),
      .stop     (stop[i]),
      .irq_clr  (irq_clr[i]),
      .count    (count[i*WIDTH +: WIDTH]),
      .pend     (irq_pend[i]),
      .state_dbg(state_dbg[2*i +: 2])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |irq_pend;
  end

endmodule

// File: tb/tb_multi_down_timer.sv
// Directed bench for multi_down_timer (WIDTH=16, NUM_CH=4).
module tb_multi_down_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_load;
  logic [3:0]  start, stop, irq_clr;
  logic [7:0]  presc_div;
  logic [63:0] count;
  logic [3:0]  irq_pend;
  logic        irq;
  logic [7:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  multi_down_timer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_load(cfg_load), .start(start), .stop(stop), .irq_clr(irq_clr),
    .presc_div(presc_div), .count(count), .irq_pend(irq_pend), .irq(irq),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cnt(int c);
    return count[c*16 +: 16];
  endfunction

  function automatic logic [1:0] st(int c);
    return state_dbg[c*2 +: 2];
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic cfg_write(int ch, logic [1:0] mode, logic [15:0] load);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = mode; cfg_load = load;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(logic [3:0] s, logic [3:0] p, logic [3:0] c);
    start = s; stop = p; irq_clr = c;
    cyc();
    start = '0; stop = '0; irq_clr = '0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_load = '0;
    start = '0; stop = '0; irq_clr = '0; presc_div = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_count", count, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_pend", irq_pend, 4'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_state", state_dbg, 8'h00);

    // ch0 cyclic load=3
    cfg_write(0, 2'b01, 16'd3);
    chk("c0_cfg_count", cnt(0), 16'd3);
    pulse(4'b0001, 4'b0000, 4'b0000);
    chk("c0_start_count", cnt(0), 16'd3);
    chk("c0_start_state", st(0), S_RUN);
    exp_q = {16'd2, 16'd1, 16'd0};
    while (exp_q.size() > 0) begin
      cyc();
      chk("c0_seq", cnt(0), exp_q.pop_front());
    end
    chk("c0_pend_before", irq_pend[0], 1'b0);
    cyc();
    chk("c0_reload", cnt(0), 16'd3);
    chk("c0_pend_set", irq_pend[0], 1'b1);
    chk("c0_irq_lag", irq, 1'b0);
    cyc();
    chk("c0_seq2", cnt(0), 16'd2);
    chk("c0_irq", irq, 1'b1);
    pulse(4'b0000, 4'b0001, 4'b0001);
    chk("c0_stop_hold", cnt(0), 16'd2);
    chk("c0_stop_state", st(0), S_IDLE);
    chk("c0_clr", irq_pend[0], 1'b0);
    cyc();
    chk("c0_irq_drop", irq, 1'b0);

    // stop at count=5
    cfg_write(0, 2'b01, 16'd7);
    pulse(4'b0001, 4'b0000, 4'b0000);
    cyc(); cyc();
    chk("stop_pre", cnt(0), 16'd5);
    pulse(4'b0000, 4'b0001, 4'b0000);
    cyc();
    chk("stop_hold5", cnt(0), 16'd5);
    chk("stop_idle", st(0), S_IDLE);
    pulse(4'b0001, 4'b0001, 4'b0000);
    chk("startstop_idle", st(0), S_IDLE);
    chk("startstop_cnt", cnt(0), 16'd5);
    start = 4'b0001;
    cfg_write(0, 2'b00, 16'd9);
    start = '0;
    cyc();
    chk("cfg_start_idle", st(0), S_IDLE);
    chk("cfg_start_cnt", cnt(0), 16'd9);

    // ch1 single-shot load=2
    cfg_write(1, 2'b10, 16'd2);
    pulse(4'b0010, 4'b0000, 4'b0000);
    exp_q = {16'd1, 16'd0, 16'd0, 16'd0};
    while (exp_q.size() > 0) begin
      cyc();
      chk("c1_seq", cnt(1), exp_q.pop_front());
    end
    chk("c1_done", st(1), S_DONE);
    chk("c1_pend", irq_pend[1], 1'b1);
    pulse(4'b0000, 4'b0000, 4'b0010);
    cyc();
    chk("c1_pend_once", irq_pend[1], 1'b0);
    pulse(4'b0010, 4'b0000, 4'b0000);
    chk("c1_restart_cnt", cnt(1), 16'd2);
    chk("c1_restart_st", st(1), S_RUN);
    cyc();
    chk("c1_rerun", cnt(1), 16'd1);
    pulse(4'b0000, 4'b0010, 4'b0000);

    // ch2 free-running load=1
    cfg_write(2, 2'b00, 16'd1);
    pulse(4'b0100, 4'b0000, 4'b0000);
    chk("c2_start", cnt(2), 16'd1);
    cyc();
    chk("c2_zero", cnt(2), 16'd0);
    cyc();
    chk("c2_wrap", cnt(2), 16'hFFFF);
    chk("c2_pend", irq_pend[2], 1'b1);
    cyc();
    chk("c2_fffe", cnt(2), 16'hFFFE);
    cfg_write(2, 2'b00, 16'd1);
    pulse(4'b0000, 4'b0000, 4'b0100);
    chk("c2_cleared", irq_pend[2], 1'b0);
    pulse(4'b0100, 4'b0000, 4'b0000);
    cyc();
    chk("c2_zero2", cnt(2), 16'd0);
    pulse(4'b0000, 4'b0000, 4'b0100);
    chk("c2_set_beats_clr", irq_pend[2], 1'b1);
    chk("c2_wrap2", cnt(2), 16'hFFFF);
    pulse(4'b0000, 4'b0100, 4'b1111);
    chk("all_cleared", irq_pend, 4'h0);

`ifdef MULTI_DOWN_TIMER_PRESCALER_EN
    begin
      int changes = 0;
      logic [15:0] prev;
      cfg_write(3, 2'b01, 16'd1);
      presc_div = 8'd3;
      pulse(4'b1000, 4'b0000, 4'b0000);
      prev = cnt(3);
      for (int k = 0; k < 8; k++) begin
        cyc();
        if (cnt(3) != prev) changes++;
        prev = cnt(3);
      end
      chk("presc_rate", changes, 2);
      pulse(4'b0000, 4'b1000, 4'b1000);
      presc_div = 8'd0;
      cyc(); cyc(); cyc(); cyc();
    end
`endif

    // all channels cyclic load=0
    for (int c = 0; c < 4; c++) cfg_write(c, 2'b01, 16'd0);
    pulse(4'b1111, 4'b0000, 4'b0000);
    chk("all_run", state_dbg, 8'h55);
    chk("all_pend_pre", irq_pend, 4'h0);
    cyc();
    chk("all_pend", irq_pend, 4'hF);
    chk("all_cnt", count, 64'h0);
    pulse(4'b0000, 4'b1111, 4'b0010);
    chk("clr_one", irq_pend, 4'b1101);
    chk("irq_held", irq, 1'b1);

    // async reset away from any clock edge
    pulse(4'b0001, 4'b0000, 4'b0000);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_count", count, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("arst_irq", irq, 1'b0);
    chk("arst_pend", irq_pend, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    chk("post_rst_idle", state_dbg, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
